// File: rtl/divide_three_detect.sv
// Serial MSB-first divisible-by-3 detector with a saturating received-bit counter.
// Optional DIV3_REMAINDER_OUT_EN adds a registered remainder[1:0] output port.
module divide_three_detect #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic             data_in,
`ifdef DIV3_REMAINDER_OUT_EN
    output logic [1:0]       remainder,
`endif
    output logic             detect_true,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_base;
    state_t           state_nx;
    logic             has_bits;
    logic             has_bits_nx;
    logic             detect_nx;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_nx;

    // clear empties the number first, so a bit arriving with clear becomes the first bit.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        state_base  = clear ? S0 : state;
        cnt_base    = clear ? '0 : bit_cnt;
        state_nx    = state_base;
        has_bits_nx = has_bits & ~clear;
        cnt_nx      = cnt_base;
        detect_nx   = detect_true & ~clear;

        if (valid) begin
            case (state_base)
                S0:      state_nx = data_in ? S1 : S0;
                S1:      state_nx = data_in ? S0 : S2;
                S2:      state_nx = data_in ? S2 : S1;
                default: state_nx = S0;
            endcase
            has_bits_nx = 1'b1;
            cnt_nx      = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
            detect_nx   = (state_nx == S0);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state       <= S0;
            has_bits    <= 1'b0;
            bit_cnt     <= '0;
            detect_true <= 1'b0;
        end else begin
            state       <= state_nx;
            has_bits    <= has_bits_nx;
            bit_cnt     <= cnt_nx;
            detect_true <= detect_nx;
        end
    end

`ifdef DIV3_REMAINDER_OUT_EN
    assign remainder = state;
`endif

endmodule

// File: tb/tb_divide_three_detect.sv
// Scoreboard bench for divide_three_detect: a wide-counter and a narrow (CNT_W=3) instance share stimulus.
// Expected responses are queued by the driver and popped by an independent monitor.
module tb_divide_three_detect;

    localparam int CNT_W_WIDE   = 8;
    localparam int CNT_W_NARROW = 3;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic valid;
    logic data_in;

    logic                    det_w;
    logic                    det_n;
    logic [CNT_W_WIDE-1:0]   cnt_w;
    logic [CNT_W_NARROW-1:0] cnt_n;
`ifdef DIV3_REMAINDER_OUT_EN
    logic [1:0] rem_w;
    logic [1:0] rem_n;
`endif

    always #5 clk = ~clk;

    divide_three_detect #(.CNT_W(CNT_W_WIDE)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .valid       (valid),
        .data_in     (data_in),
`ifdef DIV3_REMAINDER_OUT_EN
        .remainder   (rem_w),
`endif
        .detect_true (det_w),
        .bit_cnt     (cnt_w)
    );

    divide_three_detect #(.CNT_W(CNT_W_NARROW)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .valid       (valid),
        .data_in     (data_in),
`ifdef DIV3_REMAINDER_OUT_EN
        .remainder   (rem_n),
`endif
        .detect_true (det_n),
        .bit_cnt     (cnt_n)
    );

    typedef struct {
        logic  det;
        int    cnt_w;
        int    cnt_n;
        int    rem;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference number tracked as a plain integer, independent of any remainder table.
    longint model_val = 0;
    int     model_n   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock of stimulus; exp_det is the hand-computed detect value after this edge.
    task automatic step(input logic r, input logic c, input logic v, input logic d,
                        input logic exp_det, input string name);
        exp_t e;
        @(negedge clk);
        rst     = r;
        clear   = c;
        valid   = v;
        data_in = d;
        if (r) begin
            model_val = 0;
            model_n   = 0;
        end else begin
            if (c) begin
                model_val = 0;
                model_n   = 0;
            end
            if (v) begin
                model_val = model_val * 2 + longint'(d);
                model_n++;
            end
        end
        e.det   = exp_det;
        e.cnt_w = (model_n > 255) ? 255 : model_n;
        e.cnt_n = (model_n > 7) ? 7 : model_n;
        e.rem   = int'(model_val % 3);
        e.name  = name;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: outputs are registered, so each queued expectation is due just after the next edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".det"},   int'(det_w), int'(e.det));
                check({e.name, ".det3"},  int'(det_n), int'(e.det));
                check({e.name, ".cnt"},   int'(cnt_w), e.cnt_w);
                check({e.name, ".cnt3"},  int'(cnt_n), e.cnt_n);
`ifdef DIV3_REMAINDER_OUT_EN
                check({e.name, ".rem"},   int'(rem_w), e.rem);
                check({e.name, ".rem3"},  int'(rem_n), e.rem);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; valid = 1'b0; data_in = 1'b0;

        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, "idle_after_reset");

        // 1,0,0,0,1,1,1 -> 1,2,4,8,17,35,71: none divisible by 3
        step(0, 0, 1, 1, 0, "v1");
        step(0, 0, 1, 0, 0, "v2");
        step(0, 0, 1, 0, 0, "v4");
        step(0, 0, 1, 0, 0, "v8");
        step(0, 0, 1, 1, 0, "v17");
        step(0, 0, 1, 1, 0, "v35");
        step(0, 0, 1, 1, 0, "v71");

        // clear alone, then idle: empty number never flags
        step(0, 1, 0, 0, 0, "clear_only");
        step(0, 0, 0, 0, 0, "idle_empty");

        // 1,1 -> 3; 0 -> 6; hold; 1 -> 13
        step(0, 0, 1, 1, 0, "v1b");
        step(0, 0, 1, 1, 1, "v3");
        step(0, 0, 1, 0, 1, "v6");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, "hold_v6");
        step(0, 0, 1, 1, 0, "v13");

        // leading zero then 1,0,0,1 -> 9
        step(0, 1, 0, 0, 0, "clear2");
        step(0, 0, 1, 0, 1, "lead_zero");
        step(0, 0, 1, 1, 0, "lz_v1");
        step(0, 0, 1, 0, 0, "lz_v2");
        step(0, 0, 1, 0, 0, "lz_v4");
        step(0, 0, 1, 1, 1, "lz_v9");

        // clear colliding with a valid bit restarts the number at that bit
        step(0, 1, 0, 0, 0, "clear3");
        step(0, 0, 1, 1, 0, "col_v1");
        step(0, 0, 1, 0, 0, "col_v2");
        step(0, 1, 1, 1, 0, "col_restart");
        step(0, 0, 1, 1, 1, "col_v3");
        step(0, 1, 1, 0, 1, "col_restart0");

        // ten ones: 2^k-1 divisible by 3 exactly when k is even; narrow counter saturates at 7
        step(0, 1, 0, 0, 0, "clear4");
        for (int k = 1; k <= 10; k++) step(0, 0, 1, 1, logic'((k % 2) == 0), $sformatf("ones_k%0d", k));
        step(0, 0, 1, 0, 1, "ones_shift0");
        step(0, 1, 0, 0, 0, "clear_after_det");

        // reset mid-stream wins over clear and valid
        step(0, 0, 1, 1, 0, "pre_rst_v1");
        step(0, 0, 1, 1, 1, "pre_rst_v3");
        step(1, 1, 1, 0, 0, "rst_priority");
        step(0, 0, 0, 0, 0, "idle_after_rst");
        step(0, 0, 1, 0, 1, "post_rst_zero");

        @(negedge clk);
        valid = 1'b0; clear = 1'b0; rst = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/divide_three_detect.md
Name: divide_three_detect

Overview:
Serial divisible-by-3 detector. Accepts one bit per valid clock, MSB first, and treats the bits received since reset or clear as one growing unsigned binary number. It flags when that number is an exact multiple of 3. Intended as a stream-checking primitive in the base IP library, fed by a serial shifter or bit-level protocol front end.

Parameters:
CNT_W, 8, width of the saturating received-bit counter.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
clear  input  1  synchronous restart of the number; accumulated value returns to empty
valid  input  1  data_in qualifier; a bit is consumed only when valid=1
data_in  input  1  next bit of the number, MSB first
detect_true  output  1  registered; 1 when accumulated number (at least 1 bit) mod 3 == 0
bit_cnt  output  CNT_W  registered count of bits consumed since reset/clear, saturating

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (rst). All state updates only on the rising edge of clk.
- Reset values (rst=1 at a rising edge): remainder state S0, detect_true=0, bit_cnt=0, "has_bits" flag=0. rst has priority over clear and valid.
- Remainder FSM, 3 states encoding value mod 3: S0=0, S1=1, S2=2.
- On a consumed bit b, next = (2*r + b) mod 3:
  - S0: b=0 -> S0; b=1 -> S1
  - S1: b=0 -> S2; b=1 -> S0
  - S2: b=0 -> S1; b=1 -> S2
- valid=0: FSM, bit_cnt and detect_true hold. data_in is ignored.
- has_bits is set on the first consumed bit. detect_true = has_bits AND (state==S0), computed from next-state values and registered. Latency: detect_true reflects all bits consumed up to and including the bit sampled at the same edge; it becomes visible 1 cycle after data_in/valid are presented.
- Leading zeros: "0", "00" and similar strings are value 0, which is divisible by 3, so detect_true=1 once has_bits=1.
- detect_true is a level, not a pulse. It stays asserted while valid=0 or while zeros keep the state at S0.
- bit_cnt increments on each consumed bit and saturates at 2^CNT_W-1. The FSM keeps operating past saturation.
- clear=1 without valid: next state S0, has_bits=0, bit_cnt=0, detect_true=0.
- clear=1 with valid=1 in the same cycle: the number restarts with this bit as its first bit. State = b ? S1 : S0, bit_cnt=1, has_bits=1, detect_true = !b.
- rst or clear mid-stream discards all history; there are no partial-state artefacts.
- No combinational path from inputs to outputs.

Optional Feature:
Macro DIV3_REMAINDER_OUT_EN.
- Defined: an extra output port remainder [1:0] presents the registered FSM state (0/1/2), with reset value 0. It is updated with the same timing as detect_true. Encoding 3 never appears.
- Undefined: the port is absent; behaviour is otherwise identical.

Test Plan:
- Reset check: rst=1 for 5 cycles, then release -> detect_true=0, bit_cnt=0; valid=0 for 5 cycles -> outputs hold at 0.
- Stream 1,0,0,0 (valid=1 each cycle) -> values 1,2,4,8 -> detect_true 0,0,0,0; then 1 -> value 17 -> 0; then 1 -> value 35 -> 0; then 1 -> value 71 -> 0.
- Stream 1,1 -> value 3 -> detect_true=1 after the second bit. Then 0 -> value 6 -> 1. Then valid=0 for 4 cycles -> stays 1. Then 1 -> value 13 -> 0.
- Leading zero: after clear, single bit 0 -> detect_true=1, bit_cnt=1. Then bits 1,0,0,1 -> value 9 -> 1.
- Clear collision: accumulate 1,0 (value 2), then clear=1 and valid=1 with data_in=1 in the same cycle -> bit_cnt=1, detect_true=0 (remainder=1 if the macro is enabled). Then data_in=1 -> value 3 -> detect_true=1.
- Saturation with CNT_W=3: feed 10 bits of 1 -> bit_cnt stays at 7. Detection stays correct: after an even number of 1s, value 2^k-1 -> detect_true=1; after an odd number -> 0.
